// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage : bit_serial_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/bit_serial_subtractor.sv
// Bit-serial A-B over WIDTH cycles, LSB first, with a one-cycle done pulse.
// Optional two's-complement overflow output Ovf when BIT_SERIAL_SUB_OVERFLOW_EN is defined.
module bit_serial_subtractor
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    output logic             Ovf,
`endif
    output logic             Bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             load;
    logic             fs_d, fs_bout;

`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic asgn_q, asgn_d;
    logic bsgn_q, bsgn_d;
    logic ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New operands are accepted from IDLE or, back-to-back, from DONE.
    assign load = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        asgn_d  = asgn_q;
        bsgn_d  = bsgn_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    state_d = SHIFT;
                    a_d     = A;
                    b_d     = B;
                    r_d     = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
                    asgn_d  = A[WIDTH-1];
                    bsgn_d  = B[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                r_d  = {fs_d, r_q[WIDTH-1:1]};
                br_d = fs_bout;
                if (cnt_q == LAST) begin
                    // Final bit is still in flight, so publish the next-state view.
                    state_d = DONE;
                    diff_d  = {fs_d, r_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (asgn_q != bsgn_q) && (fs_d != asgn_q);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
            asgn_q  <= 1'b0;
            bsgn_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
            asgn_q  <= asgn_d;
            bsgn_q  <= bsgn_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    assign Ovf  = ovf_q;
`endif

endmodule : bit_serial_subtractor

// File: tb/tb_bit_serial_subtractor.sv
// Directed testbench for bit_serial_subtractor (WIDTH=8); checks Ovf when
// BIT_SERIAL_SUB_OVERFLOW_EN is defined.
module tb_bit_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic         Ovf;
`endif

    int vec_cnt = 0;
    int miscompares = 0;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        .Ovf   (Ovf),
`endif
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0d expected %0d", vec_cnt, tag, obs, exp);
    endtask

    // Start one operation and watch 20 cycles; operands are scrambled after
    // acceptance, and start is optionally re-pulsed with A=B=1 at cycle repulse_at.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int repulse_at,
                      output int done_at, output int done_cnt, output int busy_cnt,
                      output int diff_moves);
        logic [W-1:0] prev_diff;
        done_at = 0; done_cnt = 0; busy_cnt = 0; diff_moves = 0;
        @(negedge clk);
        prev_diff = Diff;
        A = a; B = b; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            A = ~a;
            B = a ^ 8'h5A;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (done_at == 0 && Diff !== prev_diff) diff_moves++;
            if (n == repulse_at) begin
                start = 1'b1; A = 8'd1; B = 8'd1;
            end
        end
    endtask

    int da, dc, bc, dm;
    int d1, d2;
    logic [W-1:0] diff1, diff2;
    logic bout1, bout2;

    initial begin
        // Asynchronous reset, observed between clock edges
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(Diff), 0);
        check("rst_bout", 32'(Bout), 0);
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        check("rst_ovf", 32'(Ovf), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // 100 - 58
        op(8'd100, 8'd58, 0, da, dc, bc, dm);
        check("t1_done_at", 32'(da), 9);
        check("t1_done_cnt", 32'(dc), 1);
        check("t1_busy_cnt", 32'(bc), 9);
        check("t1_diff_stable", 32'(dm), 0);
        check("t1_diff", 32'(Diff), 42);
        check("t1_bout", 32'(Bout), 0);
        check("t1_idle", 32'(busy), 0);

        // 5 - 10 wraps with borrow
        op(8'd5, 8'd10, 0, da, dc, bc, dm);
        check("t2_diff", 32'(Diff), 251);
        check("t2_bout", 32'(Bout), 1);
        check("t2_diff_stable", 32'(dm), 0);

        // 0x80 - 0x01 signed overflow
        op(8'h80, 8'h01, 0, da, dc, bc, dm);
        check("t3_diff", 32'(Diff), 32'h7F);
        check("t3_bout", 32'(Bout), 0);
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        check("t3_ovf", 32'(Ovf), 1);
`endif

        // 0x10 - 0x01 no overflow
        op(8'h10, 8'h01, 0, da, dc, bc, dm);
        check("t4_diff", 32'(Diff), 32'h0F);
        check("t4_bout", 32'(Bout), 0);
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        check("t4_ovf", 32'(Ovf), 0);
`endif

        // Boundaries: 0 - 1 and 255 - 255
        op(8'd0, 8'd1, 0, da, dc, bc, dm);
        check("t5_diff", 32'(Diff), 255);
        check("t5_bout", 32'(Bout), 1);
        op(8'd255, 8'd255, 0, da, dc, bc, dm);
        check("t6_diff", 32'(Diff), 0);
        check("t6_bout", 32'(Bout), 0);

        // start re-pulsed during SHIFT is ignored
        op(8'd9, 8'd3, 3, da, dc, bc, dm);
        check("t7_diff", 32'(Diff), 6);
        check("t7_done_cnt", 32'(dc), 1);
        check("t7_done_at", 32'(da), 9);

        // Reset mid-operation, between edges, at SHIFT cycle 4
        @(negedge clk);
        A = 8'hAA; B = 8'h11; start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("t8_pre_diff", 32'(Diff), 6);
        #2 reset = 1'b0;
        #1;
        check("t8_busy", 32'(busy), 0);
        check("t8_done", 32'(done), 0);
        check("t8_diff", 32'(Diff), 0);
        check("t8_bout", 32'(Bout), 0);
        @(negedge clk);
        reset = 1'b1;
        dc = 0; bc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) dc++;
            if (busy) bc++;
        end
        check("t8_no_done", 32'(dc), 0);
        check("t8_no_busy", 32'(bc), 0);
        op(8'd100, 8'd58, 0, da, dc, bc, dm);
        check("t8_after_done_at", 32'(da), 9);
        check("t8_after_diff", 32'(Diff), 42);

        // Back-to-back with start held high through DONE
        @(negedge clk);
        A = 8'd7; B = 8'd2; start = 1'b1;
        d1 = 0; d2 = 0; diff1 = '0; diff2 = '0; bout1 = 1'b0; bout2 = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) begin
                    d1 = n; diff1 = Diff; bout1 = Bout;
                    A = 8'd2; B = 8'd7;
                end else if (d2 == 0) begin
                    d2 = n; diff2 = Diff; bout2 = Bout;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("t9_done1_at", 32'(d1), 9);
        check("t9_gap", 32'(d2 - d1), 9);
        check("t9_diff1", 32'(diff1), 5);
        check("t9_bout1", 32'(bout1), 0);
        check("t9_diff2", 32'(diff2), 251);
        check("t9_bout2", 32'(bout2), 1);
        check("t9_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule : tb_bit_serial_subtractor

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to load operands and begin a subtraction.
REQ-005 SHALL have port A, input, WIDTH, the minuend, sampled only when start is accepted.
REQ-006 SHALL have port B, input, WIDTH, the subtrahend, sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-009 SHALL have port Diff, output, WIDTH, the registered result A-B modulo 2^WIDTH.
REQ-010 SHALL have port Bout, output, 1, the final borrow; 1 iff A<B unsigned.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-012 IDLE: start=1 at an edge SHALL load A and B into internal shift registers, clear the borrow flop and bit counter, and go to SHIFT.
REQ-013 SHIFT: each edge SHALL process the LSBs: d=a^b^br, br_next=(~a&b)|(~(a^b)&br); d SHALL shift into the result register MSB and the operands SHALL shift right, zero-filled.
REQ-014 SHALL leave SHIFT after exactly WIDTH edges and enter DONE; on that edge Diff and Bout SHALL be updated from the result register and borrow flop.
REQ-015 done SHALL be high only in DONE, exactly one cycle; latency is start-sampling edge plus WIDTH+1 edges to done high.
REQ-016 busy SHALL be high in SHIFT and DONE, low in IDLE.
REQ-017 Diff and Bout SHALL hold the last result until the next DONE entry and SHALL NOT change during SHIFT.
REQ-018 start SHALL be ignored while in SHIFT.
REQ-019 start=1 in DONE SHALL be accepted (back-to-back): load new operands, go to SHIFT; otherwise DONE goes to IDLE.
REQ-020 A and B changing outside the accepting edge SHALL have no effect.

Reset
REQ-021 reset low SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, Diff=0, Bout=0, and clear counter, borrow, and all shift registers.
REQ-022 reset asserted mid-operation SHALL abort it with no done pulse; the first start after deassertion behaves as from power-up.

Configuration
REQ-023 With macro BIT_SERIAL_SUB_OVERFLOW_EN defined, the module SHALL add output Ovf, 1 bit, the two's-complement overflow (A[MSB]!=B[MSB]) && (Diff[MSB]!=A[MSB]), updated with Diff and reset to 0.
REQ-024 Without the macro, Ovf SHALL be absent and no sign-tracking logic SHALL be present.

Structure
REQ-025 A shared package bit_serial_pkg SHALL hold the FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default-width constant 8.
REQ-026 The one-bit difference/borrow logic SHALL be a sub-module full_subtractor (ports a, b, bin, d, bout); everything else stays in bit_serial_subtractor.

Verification
REQ-027 For WIDTH=8, A=100, B=58, start pulse, the bench SHALL check done after 9 edges with Diff=42, Bout=0, and busy high for 9 cycles.
REQ-028 For A=5, B=10, the bench SHALL check Diff=251 and Bout=1.
REQ-029 For A=0x80, B=0x01, the bench SHALL check Diff=0x7F and Bout=0; with BIT_SERIAL_SUB_OVERFLOW_EN defined, Ovf=1; for A=0x10, B=0x01, Ovf=0.
REQ-030 With A=9, B=3 started, then start re-pulsed at SHIFT cycle 3 with A=1, B=1, the bench SHALL check the result Diff=6, a single done pulse, and an unchanged done time.
REQ-031 With reset driven low between clock edges at SHIFT cycle 4, the bench SHALL check that busy, done, Diff, and Bout go to 0 immediately and that no done follows.
REQ-032 With start held high through DONE for A=7,B=2 then A=2,B=7, the bench SHALL check done pulses 9 cycles apart, Diff=5 then 251, and Bout=0 then 1.
